mem_stage_wb: RTL and testbench
===============================

MEM_STAGE_WB -- requirements
Module: mem_stage_wb

Interface
REQ-001 Parameter DW, default 32: data width of store value, load value and memory data bus.
REQ-002 Parameter AW, default 32: address / ALU result / PC width.
REQ-003 Parameter DEST_W, default 4: destination register index width.
REQ-004 Parameter WBUF_DEPTH, default 4: posted write buffer entries; power of two, at least 2.
REQ-005 Ports SHALL be exactly:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- freeze  in  1  hold the stage output register.
- in_valid  in  1  instruction present at stage input.
- mem_w_en_in, mem_r_en_in, wb_en_in  in  1 each  store, load, writeback flags.
- alu_result_in  in  AW  byte address, or ALU result.
- val_rm  in  DW  store data.
- pc_in  in  AW  program counter.
- dest_in  in  DEST_W  destination register.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  AW  request address.
- mem_wdata  out  DW  write data.
- mem_ack  in  1  one-cycle completion strobe.
- mem_rdata  in  DW  read data; valid only in the mem_ack cycle.
- stall  out  1  upstream SHALL hold its inputs while high.
- out_valid, wb_en, mem_r_en  out  1 each  registered stage outputs.
- alu_result, pc  out  AW  registered.
- mem_read_value  out  DW  registered.
- dest  out  DEST_W  registered.
- wbuf_count  out  clog2(WBUF_DEPTH)+1  occupied buffer entries.

Function
REQ-006 Stores are posted: a valid store with buffer not full SHALL enqueue {alu_result_in, val_rm} at the clock edge, with no stall.
REQ-007 A valid store with buffer full (registered wbuf_count == WBUF_DEPTH) SHALL assert stall.
- The store enqueues on the first edge after the count drops.
REQ-008 Load hit:
- Condition: valid load whose address equals any buffer entry address (full AW compare).
- Data: youngest matching entry, forwarded combinationally.
- Behaviour: zero stall; no memory request issued.
REQ-009 Load miss SHALL assert stall until its read data is held internally.
REQ-010 Memory FSM states and transitions:
- IDLE -> RD_WAIT when a load miss is pending and no read result is held. Reads take priority over drains.
- IDLE -> WR_WAIT otherwise, when the buffer is non-empty; the oldest entry drains.
- RD_WAIT -> IDLE on mem_ack; mem_rdata is captured into a read-hold register and read_done is set.
- WR_WAIT -> IDLE on mem_ack; the oldest entry is dequeued.
REQ-011 mem_req, mem_we, mem_addr and mem_wdata SHALL be registered and held stable from assertion through the mem_ack cycle.
- mem_req deasserts on the edge ending the mem_ack cycle.
- At least one idle cycle follows each transaction.
REQ-012 stall deasserts for a load miss in the cycle after mem_ack, i.e. while read_done = 1.
- read_done clears when the output register captures the load.
REQ-013 Output register updates only when freeze = 0.
- stall = 1: captures a bubble (out_valid = 0, wb_en = 0, mem_r_en = 0).
- stall = 0: captures the input fields.
- mem_read_value = forwarded data (hit), read-hold data (miss), or 0 (non-load).
REQ-014 While freeze = 1, outputs hold; memory FSM, buffer drain and read completion continue.
REQ-015 Simultaneous enqueue and drain-dequeue in one cycle SHALL leave wbuf_count unchanged.
- Stores to an address already buffered append a new entry; entries never merge.
- Read and write pointers wrap modulo WBUF_DEPTH.
REQ-016 in_valid = 0 SHALL never assert stall or enqueue.
- A load with mem_w_en_in = 1 is illegal; behaviour unspecified.

Reset
REQ-017 rst low SHALL asynchronously clear:
- all outputs, wbuf_count and pointers;
- read_done and the FSM (to IDLE);
- mem_req, mem_we, mem_addr and mem_wdata.
Buffered stores are discarded; an in-flight transaction is abandoned, and a stale mem_ack after reset SHALL be ignored.

Verification
REQ-018 Store 0x10 <- 0xAAAA0001, then load 0x10 next cycle -> no stall, mem_read_value = 0xAAAA0001, no read request issued.
REQ-019 Stores to 0x20 then 0x20 (0x1, then 0x2), load 0x20 -> forwarded 0x2; buffer drains 0x1 then 0x2 in order.
REQ-020 Five stores, WBUF_DEPTH = 4, mem_ack delayed 3 cycles -> stall on the fifth store until the first drain ack; wbuf_count never exceeds 4.
REQ-021 Load miss 0x40, mem_ack after 2 cycles with rdata 0x12345678 -> stall held 4 cycles; mem_read_value = 0x12345678 with out_valid = 1; freeze during completion delays output but keeps the data.
REQ-022 rst low during WR_WAIT with 3 entries -> mem_req = 0 and wbuf_count = 0 immediately; a later mem_ack changes nothing.

Source files
------------

// File: rtl/mem_stage_wb.sv
`default_nettype none
// ============================================================================
// mem_stage_wb : memory stage with posted write buffer, load forwarding and
//                registered writeback outputs.            Revision 1.0
// ============================================================================
module mem_stage_wb #(
  parameter int DW         = 32,
  parameter int AW         = 32,
  parameter int DEST_W     = 4,
  parameter int WBUF_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          freeze,
  input  logic                          in_valid,
  input  logic                          mem_w_en_in,
  input  logic                          mem_r_en_in,
  input  logic                          wb_en_in,
  input  logic [AW-1:0]                 alu_result_in,
  input  logic [DW-1:0]                 val_rm,
  input  logic [AW-1:0]                 pc_in,
  input  logic [DEST_W-1:0]             dest_in,
  output logic                          mem_req,
  output logic                          mem_we,
  output logic [AW-1:0]                 mem_addr,
  output logic [DW-1:0]                 mem_wdata,
  input  logic                          mem_ack,
  input  logic [DW-1:0]                 mem_rdata,
  output logic                          stall,
  output logic                          out_valid,
  output logic                          wb_en,
  output logic                          mem_r_en,
  output logic [AW-1:0]                 alu_result,
  output logic [AW-1:0]                 pc,
  output logic [DW-1:0]                 mem_read_value,
  output logic [DEST_W-1:0]             dest,
  output logic [$clog2(WBUF_DEPTH):0]   wbuf_count
);

  localparam int PW = $clog2(WBUF_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   buf_addr [WBUF_DEPTH];
  logic [DW-1:0]   buf_data [WBUF_DEPTH];
  logic [PW-1:0]   wptr, rptr;
  logic [DW-1:0]   read_hold;
  logic            read_done;

  logic            is_store, is_load, full, hit, load_miss;
  logic            enq, deq, start_rd, start_wr, rd_done;
  logic [DW-1:0]   hit_data;

  assign is_store  = in_valid & mem_w_en_in;
  assign is_load   = in_valid & mem_r_en_in;
  assign full      = (wbuf_count == CW'(WBUF_DEPTH));
  assign load_miss = is_load & ~hit;
  assign stall     = (is_store & full) | (load_miss & ~read_done);
  assign enq       = is_store & ~full;

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int i = 0; i < WBUF_DEPTH; i++) begin
      if ((CW'(i) < wbuf_count) && (buf_addr[rptr + PW'(i)] == alu_result_in)) begin
        hit      = 1'b1;
        hit_data = buf_data[rptr + PW'(i)];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    start_rd  = 1'b0;
    start_wr  = 1'b0;
    rd_done   = 1'b0;
    deq       = 1'b0;
    case (state)
      IDLE: begin
        if (load_miss && !read_done) begin
          state_nxt = RD_WAIT;
          start_rd  = 1'b1;
        end else if (wbuf_count != '0) begin
          state_nxt = WR_WAIT;
          start_wr  = 1'b1;
        end
      end
      RD_WAIT: begin
        if (mem_ack) begin
          state_nxt = IDLE;
          rd_done   = 1'b1;
        end
      end
      WR_WAIT: begin
        if (mem_ack) begin
          state_nxt = IDLE;
          deq       = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      read_hold <= '0;
      read_done <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start_rd) begin
        mem_req  <= 1'b1;
        mem_we   <= 1'b0;
        mem_addr <= alu_result_in;
      end else if (start_wr) begin
        mem_req   <= 1'b1;
        mem_we    <= 1'b1;
        mem_addr  <= buf_addr[rptr];
        mem_wdata <= buf_data[rptr];
      end else if (rd_done || deq) begin
        mem_req <= 1'b0;
      end
      // The held read result lives until the output register takes the load.
      if (rd_done) begin
        read_hold <= mem_rdata;
        read_done <= 1'b1;
      end else if (read_done && !freeze) begin
        read_done <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      buf_addr[wptr] <= alu_result_in;
      buf_data[wptr] <= val_rm;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr       <= '0;
      rptr       <= '0;
      wbuf_count <= '0;
    end else begin
      if (enq) wptr <= wptr + PW'(1);
      if (deq) rptr <= rptr + PW'(1);
      case ({enq, deq})
        2'b10:   wbuf_count <= wbuf_count + CW'(1);
        2'b01:   wbuf_count <= wbuf_count - CW'(1);
        default: wbuf_count <= wbuf_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid      <= 1'b0;
      wb_en          <= 1'b0;
      mem_r_en       <= 1'b0;
      alu_result     <= '0;
      pc             <= '0;
      mem_read_value <= '0;
      dest           <= '0;
    end else if (!freeze) begin
      if (stall) begin
        out_valid      <= 1'b0;
        wb_en          <= 1'b0;
        mem_r_en       <= 1'b0;
        mem_read_value <= '0;
      end else begin
        out_valid      <= in_valid;
        wb_en          <= in_valid & wb_en_in;
        mem_r_en       <= in_valid & mem_r_en_in;
        alu_result     <= alu_result_in;
        pc             <= pc_in;
        dest           <= dest_in;
        mem_read_value <= is_load ? (hit ? hit_data : read_hold) : '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_wb.sv
`default_nettype none
// ============================================================================
// tb_mem_stage_wb : scoreboard bench for mem_stage_wb.      Revision 1.0
// ============================================================================
module tb_mem_stage_wb;
  localparam int DW = 32, AW = 32, DEST_W = 4, WBUF_DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b0, freeze = 1'b0, in_valid = 1'b0;
  logic              mem_w_en_in = 1'b0, mem_r_en_in = 1'b0, wb_en_in = 1'b0;
  logic [AW-1:0]     alu_result_in = '0, pc_in = '0;
  logic [DW-1:0]     val_rm = '0;
  logic [DEST_W-1:0] dest_in = '0;
  logic              mem_req, mem_we, stall, out_valid, wb_en, mem_r_en;
  logic [AW-1:0]     mem_addr, alu_result, pc;
  logic [DW-1:0]     mem_wdata, mem_read_value;
  logic [DW-1:0]     mem_rdata = '0;
  logic              mem_ack = 1'b0;
  logic [DEST_W-1:0] dest;
  logic [2:0]        wbuf_count;

  mem_stage_wb #(.DW(DW), .AW(AW), .DEST_W(DEST_W), .WBUF_DEPTH(WBUF_DEPTH)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .in_valid(in_valid),
    .mem_w_en_in(mem_w_en_in), .mem_r_en_in(mem_r_en_in), .wb_en_in(wb_en_in),
    .alu_result_in(alu_result_in), .val_rm(val_rm), .pc_in(pc_in), .dest_in(dest_in),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall(stall),
    .out_valid(out_valid), .wb_en(wb_en), .mem_r_en(mem_r_en),
    .alu_result(alu_result), .pc(pc), .mem_read_value(mem_read_value),
    .dest(dest), .wbuf_count(wbuf_count)
  );

  int checks = 0, failures = 0;

  typedef struct packed {
    logic [AW-1:0]     alu;
    logic [AW-1:0]     pc;
    logic [DW-1:0]     rv;
    logic [DEST_W-1:0] dest;
    logic              wb;
    logic              re;
  } out_t;
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  out_t oq[$];
  wr_t  wq[$];

  // Memory responder: acks ack_delay cycles after a request is first seen.
  int            ack_delay = 3;
  bit            mem_auto = 1'b1;
  logic          manual_ack = 1'b0;
  logic [DW-1:0] rd_value = '0;
  int            rd_count = 0;
  logic [AW-1:0] last_rd_addr = '0;
  int            age = 0;

  always @(posedge clk) begin
    wr_t w;
    #1;
    if (!mem_auto) begin
      mem_ack = manual_ack;
      age = 0;
    end else if (mem_ack) begin
      mem_ack = 1'b0;
    end else if (mem_req) begin
      if (age >= ack_delay) begin
        age = 0;
        mem_ack = 1'b1;
        if (mem_we) begin
          checks++;
          if (wq.size() == 0) begin
            failures++;
            $display("FAIL drain_unexpected addr=%h data=%h", mem_addr, mem_wdata);
          end else begin
            w = wq.pop_front();
            if (mem_addr !== w.addr || mem_wdata !== w.data) begin
              failures++;
              $display("FAIL drain_order got=%h/%h exp=%h/%h", mem_addr, mem_wdata, w.addr, w.data);
            end
          end
        end else begin
          rd_count++;
          last_rd_addr = mem_addr;
          mem_rdata = rd_value;
        end
      end else begin
        age++;
      end
    end else begin
      age = 0;
    end
  end

  // Output scoreboard: compare each captured valid instruction.
  bit         cap = 1'b0;
  logic [2:0] max_count = '0;
  always @(posedge clk) cap = rst && !freeze;

  always @(negedge clk) begin
    out_t got, e;
    if (wbuf_count > max_count) max_count = wbuf_count;
    if (cap && out_valid) begin
      checks++;
      got = '{alu: alu_result, pc: pc, rv: mem_read_value, dest: dest, wb: wb_en, re: mem_r_en};
      if (oq.size() == 0) begin
        failures++;
        $display("FAIL out_unexpected got=%h", got);
      end else begin
        e = oq.pop_front();
        if (got !== e) begin
          failures++;
          $display("FAIL out_fields got=%h exp=%h", got, e);
        end
      end
    end
  end

  task automatic send(input bit st, input bit ld, input bit wb,
                      input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [AW-1:0] p, input logic [DEST_W-1:0] ds,
                      input logic [DW-1:0] rv, output int stalls);
    out_t e;
    @(posedge clk); #1;
    in_valid = 1'b1; mem_w_en_in = st; mem_r_en_in = ld; wb_en_in = wb;
    alu_result_in = a; val_rm = d; pc_in = p; dest_in = ds;
    stalls = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!stall) break;
      stalls++;
    end
    if (stall) begin
      checks++; failures++;
      $display("FAIL send_timeout addr=%h", a);
    end
    e = '{alu: a, pc: p, rv: (ld ? rv : '0), dest: ds, wb: wb, re: ld};
    oq.push_back(e);
    if (st) wq.push_back('{addr: a, data: d});
  endtask

  task automatic idle();
    @(posedge clk); #1;
    in_valid = 1'b0; mem_w_en_in = 1'b0; mem_r_en_in = 1'b0; wb_en_in = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (wbuf_count == 3'd0 && !mem_req) break;
    end
    checks++;
    if (wbuf_count !== 3'd0 || mem_req !== 1'b0 || wq.size() != 0) begin
      failures++;
      $display("FAIL drain_done count=%0d req=%b pending=%0d exp 0/0/0", wbuf_count, mem_req, wq.size());
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({out_valid, wb_en, mem_r_en, stall, mem_req, mem_we} !== 6'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=000000", {out_valid, wb_en, mem_r_en, stall, mem_req, mem_we});
    end
    checks++;
    if (alu_result !== '0 || pc !== '0 || mem_read_value !== '0 || dest !== '0 || mem_addr !== '0 || mem_wdata !== '0) begin
      failures++;
      $display("FAIL reset_data got=%h %h %h %h exp=0", alu_result, pc, mem_read_value, mem_addr);
    end
    checks++;
    if (wbuf_count !== 3'd0) begin
      failures++;
      $display("FAIL reset_count got=%0d exp=0", wbuf_count);
    end
    @(posedge clk); #1 rst = 1'b1;
  endtask

  task automatic test_store_forward();
    int s, rc0;
    ack_delay = 3;
    rc0 = rd_count;
    send(1, 0, 0, 32'h10, 32'hAAAA0001, 32'h100, 4'd1, 32'h0, s);
    send(0, 1, 1, 32'h10, 32'h0, 32'h104, 4'd3, 32'hAAAA0001, s);
    checks++;
    if (s != 0) begin
      failures++;
      $display("FAIL fwd_stall got=%0d exp=0", s);
    end
    idle();
    wait_drain();
    checks++;
    if (rd_count != rc0) begin
      failures++;
      $display("FAIL fwd_no_read got=%0d exp=%0d", rd_count, rc0);
    end
  endtask

  task automatic test_same_addr();
    int s;
    send(1, 0, 0, 32'h20, 32'h1, 32'h110, 4'd0, 32'h0, s);
    send(1, 0, 0, 32'h20, 32'h2, 32'h114, 4'd0, 32'h0, s);
    send(0, 1, 1, 32'h20, 32'h0, 32'h118, 4'd5, 32'h2, s);
    checks++;
    if (s != 0) begin
      failures++;
      $display("FAIL youngest_stall got=%0d exp=0", s);
    end
    idle();
    wait_drain();
  endtask

  task automatic test_back_to_back();
    int s;
    ack_delay = 3;
    max_count = '0;
    for (int i = 0; i < 5; i++) begin
      send(1, 0, 0, 32'h100 + 32'(4 * i), 32'hB0 + 32'(i), 32'h400 + 32'(4 * i), 4'd0, 32'h0, s);
      checks++;
      if (s != ((i == 4) ? 2 : 0)) begin
        failures++;
        $display("FAIL full_stall store=%0d got=%0d exp=%0d", i, s, (i == 4) ? 2 : 0);
      end
    end
    idle();
    wait_drain();
    checks++;
    if (max_count !== 3'd4) begin
      failures++;
      $display("FAIL full_max_count got=%0d exp=4", max_count);
    end
  endtask

  task automatic test_load_miss();
    int s, rc0;
    ack_delay = 2;
    rd_value = 32'h12345678;
    rc0 = rd_count;
    send(0, 1, 1, 32'h40, 32'h0, 32'h200, 4'd7, 32'h12345678, s);
    checks++;
    if (s != 4) begin
      failures++;
      $display("FAIL miss_stall got=%0d exp=4", s);
    end
    idle();
    checks++;
    if (rd_count != rc0 + 1 || last_rd_addr !== 32'h40) begin
      failures++;
      $display("FAIL miss_read got=%0d/%h exp=%0d/40", rd_count, last_rd_addr, rc0 + 1);
    end
    // Second miss completes under freeze; result must survive until release.
    rd_value = 32'h0BADF00D;
    @(posedge clk); #1;
    freeze = 1'b1;
    in_valid = 1'b1; mem_r_en_in = 1'b1; wb_en_in = 1'b1;
    alu_result_in = 32'h44; pc_in = 32'h300; dest_in = 4'd9;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!stall) break;
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || mem_read_value !== '0 || stall !== 1'b0) begin
        failures++;
        $display("FAIL freeze_hold got=%b/%h/%b exp=0/0/0", out_valid, mem_read_value, stall);
      end
    end
    @(posedge clk); #1;
    freeze = 1'b0;
    oq.push_back('{alu: 32'h44, pc: 32'h300, rv: 32'h0BADF00D, dest: 4'd9, wb: 1'b1, re: 1'b1});
    idle();
    @(negedge clk);
    checks++;
    if (rd_count != rc0 + 2 || last_rd_addr !== 32'h44) begin
      failures++;
      $display("FAIL freeze_read got=%0d/%h exp=%0d/44", rd_count, last_rd_addr, rc0 + 2);
    end
  endtask

  task automatic test_reset_midflight();
    int s;
    mem_auto = 1'b0;
    send(1, 0, 0, 32'h60, 32'h61, 32'h500, 4'd0, 32'h0, s);
    send(1, 0, 0, 32'h64, 32'h65, 32'h504, 4'd0, 32'h0, s);
    send(1, 0, 0, 32'h68, 32'h69, 32'h508, 4'd0, 32'h0, s);
    idle();
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || wbuf_count !== 3'd3) begin
      failures++;
      $display("FAIL pre_reset got=%b/%b/%0d exp=1/1/3", mem_req, mem_we, wbuf_count);
    end
    #1 rst = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || wbuf_count !== 3'd0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got=%b/%0d/%b exp=0/0/0", mem_req, wbuf_count, out_valid);
    end
    wq.delete();
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk) manual_ack = 1'b1;
    @(negedge clk) manual_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b0 || wbuf_count !== 3'd0) begin
        failures++;
        $display("FAIL stale_ack got=%b/%0d exp=0/0", mem_req, wbuf_count);
      end
    end
    mem_auto = 1'b1;
  endtask

  initial begin
    test_reset();
    test_store_forward();
    test_same_addr();
    test_back_to_back();
    test_load_miss();
    test_reset_midflight();
    repeat (2) @(negedge clk);
    checks++;
    if (oq.size() != 0 || wq.size() != 0) begin
      failures++;
      $display("FAIL leftover got=%0d/%0d exp=0/0", oq.size(), wq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
